// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared types and constants for the instruction-fetch front end
//               (bus request/response structs, fetch FSM states, buffer entry).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc0_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    // Fetch sequencer states
    typedef enum logic [2:0] {
        REQ      = 3'd0,  // request presented, waiting for addr_ok
        WAIT     = 3'd1,  // address accepted, waiting for data_ok
        DROP_REQ = 3'd2,  // stale request still presented, waiting for addr_ok
        DROP     = 3'd3,  // stale request accepted, waiting to discard data_ok
        IDLE     = 3'd4   // output buffer full and stalled, no request
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    // One fetched word together with the PC it came from
    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_unit_buf.sv
// ============================================================================
// Module      : fetch_buf
// Description : One-entry output buffer holding a fetched word and its PC.
//               Flush beats fill, fill beats consume, so a word can be
//               replaced in the same cycle the previous one drains.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_buf
    import fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         fill,
    input  logic         consume,
    input  logic         flush,
    input  fetch_entry_t fill_entry,
    output logic         valid,
    output fetch_entry_t entry
);

    // Entry register; contents are only rewritten on fill so a stalled word stays bit-stable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            entry <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (fill) begin
            valid <= 1'b1;
            entry <= fill_entry;
        end else if (consume) begin
            valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch front end. Owns the fetch PC, keeps at most
//               one instruction-bus transaction outstanding, buffers one word
//               for the pre-decode stage and discards responses made stale by
//               a redirect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output ibus_resp_t  out_resp,
    output logic [31:0] out_pc
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  pc;
    logic [31:0]  pc_next;
    logic [31:0]  stale_addr;       // address of a superseded request still on the bus
    logic [31:0]  stale_addr_next;
    logic         fault_hold;       // misaligned-PC word already emitted, wait for redirect
    logic         fault_hold_next;

    logic         req_valid;
    logic [31:0]  req_addr;
    logic         req_accept;

    logic         buf_valid;
    fetch_entry_t buf_entry;
    logic         buf_fill;
    logic         buf_flush;
    fetch_entry_t fill_entry;
    logic         buf_consume;
    logic         buf_free;

    assign buf_consume = buf_valid && !stall;
    // Free means empty now or draining this cycle; once true it stays true until we fill
    assign buf_free    = !buf_valid || !stall;
    assign req_accept  = req_valid && iresp.addr_ok;

    fetch_buf u_buf (
        .clk        (clk),
        .reset      (reset),
        .fill       (buf_fill),
        .consume    (buf_consume),
        .flush      (buf_flush),
        .fill_entry (fill_entry),
        .valid      (buf_valid),
        .entry      (buf_entry)
    );

    // Request generation: new requests only when the response has somewhere to land;
    // a stale request keeps its original address until the bus accepts it
    always_comb begin
        req_valid = 1'b0;
        req_addr  = pc;
        case (state)
            REQ:      req_valid = is_aligned(pc) && buf_free;
            DROP_REQ: begin
                req_valid = 1'b1;
                req_addr  = stale_addr;
            end
            default:  req_valid = 1'b0;
        endcase
    end

    assign ireq     = '{valid: req_valid && !reset, addr: req_addr};
    assign out_resp = '{addr_ok: 1'b0, data_ok: buf_valid, data: buf_entry.data};
    assign out_pc   = buf_entry.pc;

    // State, PC and bookkeeping registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= REQ;
            pc         <= RESET_PC;
            stale_addr <= '0;
            fault_hold <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            stale_addr <= stale_addr_next;
            fault_hold <= fault_hold_next;
        end
    end

    // Next-state logic; a redirect overrides everything and never lets data into the buffer
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        stale_addr_next = stale_addr;
        fault_hold_next = fault_hold;
        buf_fill        = 1'b0;
        buf_flush       = 1'b0;
        fill_entry      = '{data: iresp.data, pc: pc};

        if (redirect_valid) begin
            pc_next         = redirect_pc;
            buf_flush       = 1'b1;
            fault_hold_next = 1'b0;
            case (state)
                REQ: begin
                    if (req_accept) begin
                        state_next = iresp.data_ok ? REQ : DROP;
                    end else if (req_valid) begin
                        state_next      = DROP_REQ;
                        stale_addr_next = pc;
                    end else begin
                        state_next = REQ;
                    end
                end
                WAIT:     state_next = iresp.data_ok ? REQ : DROP;
                DROP_REQ: begin
                    if (iresp.addr_ok) begin
                        state_next = iresp.data_ok ? REQ : DROP;
                    end
                end
                DROP: begin
                    if (iresp.data_ok) begin
                        state_next = REQ;
                    end
                end
                default:  state_next = REQ;
            endcase
        end else begin
            case (state)
                REQ: begin
                    if (!is_aligned(pc)) begin
                        // Emit a single zero word so decode raises the address error
                        if (!fault_hold && buf_free) begin
                            buf_fill        = 1'b1;
                            fill_entry      = '{data: 32'd0, pc: pc};
                            fault_hold_next = 1'b1;
                        end
                    end else if (req_accept) begin
                        if (iresp.data_ok) begin
                            buf_fill   = 1'b1;
                            pc_next    = pc + PC_STEP;
                            state_next = stall ? IDLE : REQ;
                        end else begin
                            state_next = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (iresp.data_ok) begin
                        buf_fill   = 1'b1;
                        pc_next    = pc + PC_STEP;
                        state_next = stall ? IDLE : REQ;
                    end
                end
                DROP_REQ: begin
                    if (iresp.addr_ok) begin
                        state_next = iresp.data_ok ? REQ : DROP;
                    end
                end
                DROP: begin
                    if (iresp.data_ok) begin
                        state_next = REQ;
                    end
                end
                IDLE: begin
                    if (buf_consume) begin
                        state_next = REQ;
                    end
                end
                default: state_next = REQ;
            endcase
        end
    end

endmodule

`default_nettype wire
